// File: rtl/clock_period_meter_if.sv
// clock_period_meter_if: signal/status bundle between a slow-clock source and the period meter
//   sig_in        slow clock under measurement (driven by master)
//   period_out    last rising-to-rising period, clk_in cycles
//   high_time_out last rising-to-falling high time, clk_in cycles
//   period_valid  one-cycle pulse on period_out update
//   locked        frequency lock status
//   lost          sticky loss-of-signal flag
interface clock_period_meter_if #(parameter int CNT_WIDTH = 16);
  logic sig_in;
  logic [CNT_WIDTH-1:0] period_out;
  logic [CNT_WIDTH-1:0] high_time_out;
  logic period_valid;
  logic locked;
  logic lost;
  modport master (output sig_in, input period_out, high_time_out, period_valid, locked, lost);
  modport slave (input sig_in, output period_out, high_time_out, period_valid, locked, lost);
endinterface

// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period/high time of an async slow clock in clk_in cycles, with lock and loss status
//   clk_in  system clock
//   reset   asynchronous active-high reset, clears all state
//   bus     slave side of clock_period_meter_if (sig_in in; period_out, high_time_out, period_valid, locked, lost out)
module clock_period_meter #(
  parameter int EXPECTED_PERIOD = 28000,
  parameter int TOLERANCE = 64,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT = 56000,
  parameter int CNT_WIDTH = 16
) (
  input logic clk_in,
  input logic reset,
  clock_period_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} state_t;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  localparam logic signed [CNT_WIDTH+1:0] EXP = (CNT_WIDTH+2)'(EXPECTED_PERIOD);
  localparam logic signed [CNT_WIDTH+1:0] TOL = (CNT_WIDTH+2)'(TOLERANCE);
  localparam logic signed [CNT_WIDTH+1:0] NTOL = (CNT_WIDTH+2)'(-TOLERANCE);
  state_t state, state_n;
  logic s1, s2, s3, rise, fall, timeout, capture, in_tol, seen, valid, lost;
  logic [3:0] lock_cnt, lock_cnt_n;
  logic [CNT_WIDTH-1:0] pcnt, hcnt, pcnt_inc, hcnt_inc, period, high_time;
  logic signed [CNT_WIDTH+1:0] diff;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign pcnt_inc = pcnt == CMAX ? pcnt : pcnt + 1'b1;
  assign hcnt_inc = hcnt == CMAX ? hcnt : hcnt + 1'b1;
  // pcnt_inc is the period ending on this rise; compare it before it is registered
  assign diff = $signed({2'b00, pcnt_inc}) - EXP;
  assign in_tol = diff <= TOL && diff >= NTOL;
  // a rise landing in the timeout cycle restarts the period instead of declaring loss
  assign timeout = state != IDLE && !rise && pcnt == TO_LAST;
  always_comb begin
    state_n = state;
    lock_cnt_n = lock_cnt;
    capture = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      lock_cnt_n = '0;
    end else if (rise && state == IDLE) begin
      state_n = ACQUIRE;
    end else if (rise) begin
      capture = 1'b1;
      if (state == ACQUIRE) begin
        state_n = TRACK;
        lock_cnt_n = in_tol ? 4'd1 : 4'd0;
      end else if (!in_tol) begin
        state_n = TRACK;
        lock_cnt_n = '0;
      end else if (state == TRACK) begin
        lock_cnt_n = lock_cnt + 1'b1;
        state_n = lock_cnt + 1'b1 == LC ? LOCKED : TRACK;
      end
    end
  end
  always_ff @(posedge clk_in or posedge reset)
    if (reset) begin
      {s1, s2, s3} <= '0;
      pcnt <= '0;
      hcnt <= '0;
      state <= IDLE;
      lock_cnt <= '0;
      seen <= 1'b0;
      lost <= 1'b0;
      valid <= 1'b0;
      period <= '0;
      high_time <= '0;
    end else begin
      s1 <= bus.sig_in;
      s2 <= s1;
      s3 <= s2;
      pcnt <= rise ? '0 : pcnt_inc;
      hcnt <= rise ? '0 : s2 ? hcnt_inc : hcnt;
      state <= state_n;
      lock_cnt <= lock_cnt_n;
      seen <= rise | (seen & ~timeout);
      lost <= timeout | (lost & ~rise);
      valid <= capture;
      if (capture) period <= pcnt_inc;
      // a fall without a preceding rise has no valid start reference
      if (fall && seen) high_time <= hcnt_inc;
    end
  assign bus.period_out = period;
  assign bus.high_time_out = high_time;
  assign bus.period_valid = valid;
  assign bus.locked = state == LOCKED;
  assign bus.lost = lost;
endmodule

// File: tb/tb_clock_period_meter.sv
// tb_clock_period_meter: directed scoreboard bench for clock_period_meter on scaled-down parameters
module tb_clock_period_meter;
  localparam int EP = 200;
  localparam int TOL = 8;
  localparam int LC = 4;
  localparam int TO = 400;
  typedef struct {int p; int h; logic l;} exp_t;
  logic clk_in = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int t = 0;
  int last_rise = 0;
  int last_hi = 0;
  int cnt = 0;
  bit have_ref = 1'b0;
  exp_t q[$];
  clock_period_meter_if #(.CNT_WIDTH(16)) bus();
  clock_period_meter #(.EXPECTED_PERIOD(EP), .TOLERANCE(TOL), .LOCK_COUNT(LC), .TIMEOUT(TO), .CNT_WIDTH(16)) dut (
    .clk_in(clk_in),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  // drives sig_in for n clk_in cycles; each rise after a reference rise queues the expected measurement
  task automatic drive(input logic v, input int n);
    if (v && !bus.sig_in) begin
      if (have_ref) begin
        int d;
        d = t - last_rise;
        cnt = (d >= EP - TOL && d <= EP + TOL) ? cnt + 1 : 0;
        q.push_back('{d, last_hi, cnt >= LC});
      end
      have_ref = 1'b1;
      last_rise = t;
    end
    if (!v && bus.sig_in) last_hi = t - last_rise;
    bus.sig_in = v;
    repeat (n) @(negedge clk_in);
    t += n;
  endtask
  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, 32'(bus.period_out), 0);
    chk({tag, "_high"}, 32'(bus.high_time_out), 0);
    chk({tag, "_valid"}, 32'(bus.period_valid), 0);
    chk({tag, "_locked"}, 32'(bus.locked), 0);
    chk({tag, "_lost"}, 32'(bus.lost), 0);
  endtask
  always @(negedge clk_in)
    if (bus.period_valid === 1'b1) begin
      exp_t e;
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = q.pop_front();
        chk("period", 32'(bus.period_out), e.p);
        chk("high_time", 32'(bus.high_time_out), e.h);
        chk("locked_at_valid", 32'(bus.locked), 32'(e.l));
      end
    end
  initial begin
    bus.sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk_zero("reset");
    reset = 1'b0;
    drive(1'b0, 10);
    repeat (6) pulse(100, 100);
    chk("lock_50pct", 32'(bus.locked), 1);
    pulse(100, 108);
    pulse(100, 109);
    repeat (4) pulse(100, 100);
    pulse(100, 92);
    pulse(100, 91);
    repeat (4) pulse(100, 100);
    drive(1'b1, 100);
    drive(1'b0, TO + 2 - 100);
    chk("pre_loss_lost", 32'(bus.lost), 0);
    chk("pre_loss_locked", 32'(bus.locked), 1);
    drive(1'b0, 1);
    chk("loss_lost", 32'(bus.lost), 1);
    chk("loss_locked", 32'(bus.locked), 0);
    have_ref = 1'b0;
    cnt = 0;
    drive(1'b1, 3);
    chk("loss_clear", 32'(bus.lost), 0);
    drive(1'b1, 97);
    drive(1'b0, 100);
    pulse(100, TO - 100);
    drive(1'b1, 3);
    chk("race_no_lost", 32'(bus.lost), 0);
    drive(1'b1, 97);
    drive(1'b0, 100);
    repeat (6) pulse(100, 100);
    drive(1'b1, 70);
    chk("pre_reset_locked", 32'(bus.locked), 1);
    reset = 1'b1;
    #1;
    chk_zero("mid_reset");
    drive(1'b0, 5);
    reset = 1'b0;
    have_ref = 1'b0;
    cnt = 0;
    drive(1'b0, 10);
    repeat (6) pulse(50, 150);
    drive(1'b1, 10);
    chk("duty_locked", 32'(bus.locked), 1);
    chk("duty_high", 32'(bus.high_time_out), 50);
    drive(1'b0, 10);
    chk("queue_drained", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
